// File: rtl/ctrl_pkg.sv
// Shared definitions for the ula_ctrl sequencer: opcodes, ALU codes,
// FSM state encoding and the bit positions of the latched IR fields.
package ctrl_pkg;

   localparam int NREG   = 8;   // register count, fixed by 3-bit fields
   localparam int IR_W   = 9;   // IR keeps only opcode, rX and rY
   localparam int OP_HI  = 8;
   localparam int OP_LO  = 6;
   localparam int RX_HI  = 5;
   localparam int RX_LO  = 3;
   localparam int RY_HI  = 2;
   localparam int RY_LO  = 0;

   typedef enum logic [2:0] {
      OP_MV   = 3'd0,
      OP_MVI  = 3'd1,
      OP_ADD  = 3'd2,
      OP_SUB  = 3'd3,
      OP_NAND = 3'd4,
      OP_MVNZ = 3'd5,
      OP_RSV6 = 3'd6,
      OP_RSV7 = 3'd7
   } opcode_t;

   typedef enum logic [1:0] {
      ULA_ADD  = 2'd0,
      ULA_SUB  = 2'd1,
      ULA_NAND = 2'd2,
      ULA_NOP  = 2'd3
   } ula_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_T1   = 2'd1,
      S_T2   = 2'd2,
      S_T3   = 2'd3
   } state_t;

endpackage

// File: rtl/dec3to8.sv
// 3-bit to one-hot 8 decoder with enable; used for the register load
// and register bus-drive enables.
module dec3to8 (
   input  logic       en,
   input  logic [2:0] sel,
   output logic [7:0] y
);

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         assign y[gi] = en && (sel == 3'(gi));
      end
   endgenerate

endmodule

// File: rtl/ula_ctrl.sv
// Multi-cycle instruction sequencer for the 16-bit datapath.
// Optional feature: define MVNZ_EN to decode opcode 5 as mvnz
// (move if G is non-zero); otherwise opcode 5 is reserved.
module ula_ctrl
   import ctrl_pkg::*;
#(
   parameter int IW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic [IW-1:0]   din,
   input  logic            g_zero,
   output logic            ir_in,
   output logic [NREG-1:0] r_in,
   output logic [NREG-1:0] r_out,
   output logic            din_out,
   output logic            a_in,
   output logic            g_in,
   output logic            g_out,
   output logic [1:0]      op_select,
   output logic            done
);

   state_t            state_reg, state_next;
   logic [IR_W-1:0]   ir_reg, ir_next;
   opcode_t           opcode;
   logic [2:0]        rx, ry;
   logic              rin_en, rout_en;
   logic [2:0]        rin_sel, rout_sel;
   logic              unused_bits;

   assign opcode = opcode_t'(ir_reg[OP_HI:OP_LO]);
   assign rx     = ir_reg[RX_HI:RX_LO];
   assign ry     = ir_reg[RY_HI:RY_LO];

   // Low instruction bits carry no meaning; g_zero only matters for mvnz.
   assign unused_bits = ^{din[IW-IR_W-1:0], g_zero};

   dec3to8 u_dec_in  (.en(rin_en),  .sel(rin_sel),  .y(r_in));
   dec3to8 u_dec_out (.en(rout_en), .sel(rout_sel), .y(r_out));

   // State and instruction register; reset aborts any instruction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         ir_reg    <= '0;
      end else begin
         state_reg <= state_next;
         ir_reg    <= ir_next;
      end
   end

   // Next-state and control outputs; everything is forced idle while reset is high.
   always_comb begin
      state_next = state_reg;
      ir_next    = ir_reg;
      ir_in      = 1'b0;
      rin_en     = 1'b0;
      rin_sel    = rx;
      rout_en    = 1'b0;
      rout_sel   = ry;
      din_out    = 1'b0;
      a_in       = 1'b0;
      g_in       = 1'b0;
      g_out      = 1'b0;
      op_select  = ULA_NOP;
      done       = 1'b0;
      if (!reset) begin
         case (state_reg)
            S_IDLE: begin
               if (run) begin
                  ir_in      = 1'b1;
                  ir_next    = din[IW-1 -: IR_W];
                  state_next = S_T1;
               end
            end
            S_T1: begin
               state_next = S_IDLE;
               case (opcode)
                  OP_MV: begin
                     rout_en = 1'b1;
                     rin_en  = 1'b1;
                     done    = 1'b1;
                  end
                  OP_MVI: begin
                     din_out = 1'b1;
                     rin_en  = 1'b1;
                     done    = 1'b1;
                  end
                  OP_ADD, OP_SUB, OP_NAND: begin
                     rout_sel   = rx;
                     rout_en    = 1'b1;
                     a_in       = 1'b1;
                     state_next = S_T2;
                  end
`ifdef MVNZ_EN
                  OP_MVNZ: begin
                     rout_en = !g_zero;
                     rin_en  = !g_zero;
                     done    = 1'b1;
                  end
`endif
                  default: begin
                     done = 1'b1;
                  end
               endcase
            end
            S_T2: begin
               rout_en    = 1'b1;
               g_in       = 1'b1;
               state_next = S_T3;
               case (opcode)
                  OP_ADD:  op_select = ULA_ADD;
                  OP_SUB:  op_select = ULA_SUB;
                  OP_NAND: op_select = ULA_NAND;
                  default: op_select = ULA_NOP;
               endcase
            end
            S_T3: begin
               g_out      = 1'b1;
               rin_en     = 1'b1;
               done       = 1'b1;
               state_next = S_IDLE;
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ula_ctrl.sv
// Testbench for ula_ctrl: directed instruction sequence, a scoreboard of
// per-cycle expected control vectors, and a small datapath model that
// executes the control outputs so register results can be checked.
module tb_ula_ctrl;

   typedef struct packed {
      logic       ir_in;
      logic [7:0] r_in;
      logic [7:0] r_out;
      logic       din_out;
      logic       a_in;
      logic       g_in;
      logic       g_out;
      logic [1:0] op;
      logic       done;
   } outv_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [15:0] din;
   logic        g_zero;
   logic        ir_in;
   logic [7:0]  r_in;
   logic [7:0]  r_out;
   logic        din_out;
   logic        a_in;
   logic        g_in;
   logic        g_out;
   logic [1:0]  op_select;
   logic        done;

   outv_t       obs;
   outv_t       exp_q[$];
   string       tag_q[$];
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   int          fail_cnt  = 0;

   // datapath model
   logic [15:0] regs_m [8] = '{default: 16'h0000};
   logic [15:0] a_m = 16'h0;
   logic [15:0] g_m = 16'h0;
   logic [15:0] bus_m;

   always #5 clk = ~clk;

   ula_ctrl #(.IW(16)) dut (
      .clk(clk), .reset(reset), .run(run), .din(din), .g_zero(g_zero),
      .ir_in(ir_in), .r_in(r_in), .r_out(r_out), .din_out(din_out),
      .a_in(a_in), .g_in(g_in), .g_out(g_out), .op_select(op_select),
      .done(done)
   );

   assign obs = {ir_in, r_in, r_out, din_out, a_in, g_in, g_out, op_select, done};

   always_comb begin
      bus_m = 16'h0;
      if (din_out) bus_m = din;
      else if (g_out) bus_m = g_m;
      else for (int i = 0; i < 8; i++) if (r_out[i]) bus_m = regs_m[i];
   end

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) if (r_in[i]) regs_m[i] <= bus_m;
      if (a_in) a_m <= bus_m;
      if (g_in) begin
         case (op_select)
            2'd0:    g_m <= a_m + bus_m;
            2'd1:    g_m <= a_m - bus_m;
            2'd2:    g_m <= ~(a_m & bus_m);
            default: g_m <= bus_m;
         endcase
      end
   end

   // scoreboard: compare DUT outputs against the vector queued for this cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin : mon
         outv_t e;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         total_cnt++;
         assert (obs === e) pass_cnt++;
         else begin
            fail_cnt++;
            $display("FAIL %s: observed %h expected %h", t, obs, e);
            $error("%s observed %h expected %h", t, obs, e);
         end
      end
   end

   function automatic outv_t nop_v();
      outv_t v;
      v = '0;
      v.op = 2'd3;
      return v;
   endfunction

   task automatic cyc(input logic [15:0] d, input logic r, input logic rs,
                      input outv_t e, input string tag);
      reset = rs;
      din   = d;
      run   = r;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   // Drive one instruction; expectations for each cycle are queued as driven.
   // abort_t2 asserts reset in the T2 cycle of an ALU instruction.
   task automatic instr(input logic [2:0] op, input logic [2:0] rx,
                        input logic [2:0] ry, input logic [15:0] imm,
                        input logic hold, input logic gz,
                        input logic abort_t2, input string tag);
      outv_t e;
      e = nop_v();
      e.ir_in = 1'b1;
      g_zero = gz;
      cyc({op, rx, ry, 7'h2A}, 1'b1, 1'b0, e, {tag, " idle"});
      e = nop_v();
      case (op)
         3'd0: begin e.r_out = 8'b1 << ry; e.r_in = 8'b1 << rx; e.done = 1'b1; end
         3'd1: begin e.din_out = 1'b1; e.r_in = 8'b1 << rx; e.done = 1'b1; end
         3'd2, 3'd3, 3'd4: begin e.r_out = 8'b1 << rx; e.a_in = 1'b1; end
         3'd5: begin
`ifdef MVNZ_EN
            if (!gz) begin e.r_out = 8'b1 << ry; e.r_in = 8'b1 << rx; end
`endif
            e.done = 1'b1;
         end
         default: e.done = 1'b1;
      endcase
      cyc(imm, hold, 1'b0, e, {tag, " t1"});
      if (op == 3'd2 || op == 3'd3 || op == 3'd4) begin
         if (abort_t2) begin
            cyc(imm, 1'b1, 1'b1, nop_v(), {tag, " reset_t2"});
            cyc(imm, 1'b0, 1'b0, nop_v(), {tag, " after_reset"});
         end else begin
            e = nop_v();
            e.r_out = 8'b1 << ry;
            e.g_in  = 1'b1;
            e.op    = (op == 3'd2) ? 2'd0 : (op == 3'd3) ? 2'd1 : 2'd2;
            cyc(imm, hold, 1'b0, e, {tag, " t2"});
            e = nop_v();
            e.g_out = 1'b1;
            e.r_in  = 8'b1 << rx;
            e.done  = 1'b1;
            cyc(imm, hold, 1'b0, e, {tag, " t3"});
         end
      end
   endtask

   task automatic chk_reg(input int idx, input logic [15:0] val, input string tag);
      total_cnt++;
      assert (regs_m[idx] === val) pass_cnt++;
      else begin
         fail_cnt++;
         $display("FAIL %s: R%0d observed %h expected %h", tag, idx, regs_m[idx], val);
         $error("%s R%0d observed %h expected %h", tag, idx, regs_m[idx], val);
      end
   endtask

   initial begin
      reset  = 1'b1;
      run    = 1'b1;
      din    = 16'h2400;
      g_zero = 1'b0;
      @(posedge clk);
      #1;
      // outputs stay idle under reset even with run high
      cyc(16'h2400, 1'b1, 1'b1, nop_v(), "reset0");
      cyc(16'h2400, 1'b1, 1'b1, nop_v(), "reset1");
      cyc(16'h0000, 1'b0, 1'b0, nop_v(), "idle_norun");

      instr(3'd1, 3'd1, 3'd0, 16'h00AB, 1'b0, 1'b0, 1'b0, "mvi_r1");
      chk_reg(1, 16'h00AB, "mvi_r1_val");

      instr(3'd1, 3'd2, 3'd0, 16'h0005, 1'b0, 1'b0, 1'b0, "mvi_r2");
      instr(3'd1, 3'd3, 3'd0, 16'h0007, 1'b0, 1'b0, 1'b0, "mvi_r3");
      instr(3'd2, 3'd2, 3'd3, 16'h0000, 1'b0, 1'b0, 1'b0, "add_r2_r3");
      chk_reg(2, 16'h000C, "add_val");

      instr(3'd1, 3'd4, 3'd0, 16'h0003, 1'b0, 1'b0, 1'b0, "mvi_r4");
      instr(3'd1, 3'd5, 3'd0, 16'h0005, 1'b0, 1'b0, 1'b0, "mvi_r5");
      instr(3'd3, 3'd4, 3'd5, 16'h0000, 1'b0, 1'b0, 1'b0, "sub_r4_r5");
      chk_reg(4, 16'hFFFE, "sub_val");

      instr(3'd1, 3'd4, 3'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, "mvi_r4b");
      instr(3'd0, 3'd5, 3'd4, 16'h0000, 1'b0, 1'b0, 1'b0, "mv_r5_r4");
      chk_reg(5, 16'hFFFF, "mv_val");
      instr(3'd4, 3'd4, 3'd5, 16'h0000, 1'b0, 1'b0, 1'b0, "nand_r4_r5");
      chk_reg(4, 16'h0000, "nand_val");

      // run held high across the whole add: no second ir_in while busy
      instr(3'd2, 3'd2, 3'd2, 16'h0000, 1'b1, 1'b0, 1'b0, "add_busy");
      chk_reg(2, 16'h0018, "add_rr_val");
      cyc(16'h0000, 1'b0, 1'b0, nop_v(), "idle_after_busy");

      instr(3'd7, 3'd3, 3'd1, 16'h0000, 1'b0, 1'b0, 1'b0, "rsv7");
      chk_reg(3, 16'h0007, "rsv7_noload");
      instr(3'd6, 3'd3, 3'd1, 16'h0000, 1'b0, 1'b0, 1'b0, "rsv6");

      instr(3'd5, 3'd6, 3'd1, 16'h0000, 1'b0, 1'b0, 1'b0, "op5_gz0");
`ifdef MVNZ_EN
      chk_reg(6, 16'h00AB, "op5_gz0_val");
`else
      chk_reg(6, 16'h0000, "op5_gz0_val");
`endif
      instr(3'd5, 3'd7, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b0, "op5_gz1");
      chk_reg(7, 16'h0000, "op5_gz1_val");

      // reset in T2 of an add aborts it; R2 keeps its value
      instr(3'd2, 3'd2, 3'd3, 16'h0000, 1'b0, 1'b0, 1'b1, "add_abort");
      chk_reg(2, 16'h0018, "abort_noload");
      instr(3'd1, 3'd7, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0, "mvi_after_reset");
      chk_reg(7, 16'h1234, "mvi_after_reset_val");

      cyc(16'h0000, 1'b0, 1'b0, nop_v(), "idle_end");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      total_cnt++;
      assert (exp_q.size() == 0) pass_cnt++;
      else begin
         fail_cnt++;
         $display("FAIL drain: pending %0d expected 0", exp_q.size());
      end
      #1;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ula_ctrl.md
Name: ula_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit processor datapath: decodes one instruction word and drives bus-source selects, register load enables and the ALU `op_select` code.
- ALU codes: 0 add, 1 sub, 2 nand, 3 no_op.
- Sits between the instruction source (`din` and `run`) and the datapath (register file R0-R7, A latch, G result register, shared bus).
- One instruction in flight at a time; `done` pulses when it retires.

Parameters:
- IW, 16, instruction word width; fields decoded from the top 9 bits.
- NREG, 8, number of registers; fixed by the 3-bit register fields, so not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  start request; sampled only in IDLE.
- din  in  IW  instruction word (IDLE) or immediate word (T1 of mvi).
- g_zero  in  1  G register == 0; used only under MVNZ_EN.
- ir_in  out  1  load internal IR / instruction-latched strobe.
- r_in  out  8  one-hot register load enables.
- r_out  out  8  one-hot register bus-drive enables.
- din_out  out  1  drive `din` onto the bus.
- a_in  out  1  load the A latch from the bus.
- g_in  out  1  load G from the ALU result.
- g_out  out  1  drive G onto the bus.
- op_select  out  2  ALU operation code.
- done  out  1  one-cycle retire pulse.

Behaviour:
- Instruction fields: `opcode = din[15:13]`, `rX = din[12:10]`, `rY = din[9:7]`; `din[6:0]` ignored.
- Opcodes: 0 mv, 1 mvi, 2 add, 3 sub, 4 nand, 5 mvnz (optional), 6-7 reserved.
- Reset (any cycle, including mid-instruction): state goes to IDLE, IR cleared. During and after reset, all enables, `ir_in` and `done` are 0, and `op_select` = 3.
- Outputs are combinational from state, IR and `run`.
- `op_select` = 3 in every state except T2.
- At most one bit set in each of `r_in` and `r_out`.
- IDLE:
  - `run` = 1: `ir_in` = 1, IR <= `din[15:7]`, next state T1.
  - `run` = 0: stay in IDLE.
- T1 (the IR field is the latched value):
  - mv: `r_out[rY]`, `r_in[rX]`, `done`; next IDLE.
  - mvi: `din_out`, `r_in[rX]`, `done`; next IDLE. The immediate must be valid on `din` in this cycle.
  - add/sub/nand: `r_out[rX]`, `a_in`; next T2.
  - opcodes 5-7 (5 when MVNZ_EN is off): `done` only, no enables; next IDLE.
- T2:
  - `r_out[rY]`, `g_in`; next T3.
  - `op_select` = 0 for add, 1 for sub, 2 for nand.
- T3: `g_out`, `r_in[rX]`, `done`; next IDLE.
- Latency from the `run`-sampled edge to `done`: 1 cycle for mv/mvi/reserved opcodes; 3 cycles for ALU operations.
- Back-to-back instructions: after `done`, the next IDLE cycle may accept `run` immediately, so sustained throughput is one instruction per 2 or 4 cycles.
- `run` asserted while not in IDLE is ignored; it is neither queued nor aborting.
- `rX == rY` is legal (e.g. add R2,R2 doubles R2); no special handling.
- Arithmetic width and wrap are owned by the ALU; the controller never inspects data except `g_zero`.

Optional Feature:
- Macro: MVNZ_EN.
- Defined: opcode 5 is mvnz.
  - In T1, if `g_zero` = 0: `r_out[rY]`, `r_in[rX]`, `done`.
  - If `g_zero` = 1: `done` only.
  - Either way, next IDLE.
- Undefined: opcode 5 is reserved (`done` only, no enables); the `g_zero` input exists but is unused.

Decomposition:
- Shared package `ctrl_pkg`:
  - opcode constants OP_MV..OP_MVNZ;
  - ALU codes ULA_ADD=0, ULA_SUB=1, ULA_NAND=2, ULA_NOP=3;
  - state encoding S_IDLE, S_T1, S_T2, S_T3 (2-bit);
  - IR field bit positions.
- Sub-module `dec3to8`: 3-bit to one-hot 8 decoder with enable, instantiated for `r_in` and `r_out`.

Test Plan:
- Reset: reset=1 during T2 of an add -> next cycle state IDLE, `op_select` = 3, all enables 0, `done` = 0; a subsequent run starts cleanly.
- mvi: `din` = 16'h2400 (mvi R1) with run=1, then `din` = 16'h00AB -> T1 `din_out` = 1, `r_in` = 8'b0000_0010, `done` = 1; R1 = 16'h00AB.
- add: mv/mvi preload R2 = 5, R3 = 7; `din` = opcode 2, rX=2, rY=3 -> T1 `r_out` = 8'h04, `a_in`; T2 `op_select` = 0, `r_out` = 8'h08, `g_in`; T3 `g_out`, `r_in` = 8'h04, `done`; R2 = 12, 3 cycles after the run edge.
- sub/nand: R4 = 16'h0003, R5 = 16'h0005; sub R4,R5 -> R4 = 16'hFFFE, T2 `op_select` = 1; nand with R4 = R5 = 16'hFFFF -> 16'h0000, `op_select` = 2.
- Busy/reserved: run held high throughout a 3-cycle add -> no second `ir_in` until IDLE. Opcode 7 -> `done` after 1 cycle, no enables asserted.
- MVNZ_EN:
  - `g_zero` = 0 -> `r_in`/`r_out` asserted in T1.
  - `g_zero` = 1 -> only `done`.
  - Build without the macro -> opcode 5 behaves as reserved.
